multicycle_ctrl: RTL and testbench

//  Parametrised multi-cycle sequencer for the 16-bit accumulator CPU; drives PC, IR, A/B, ALU, regfile and memory enables.

---
 rtl/multicycle_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the 16-bit accumulator CPU.
// Steps each instruction through fetch/decode/exec/mem/writeback. Memory
// accesses can stall on MemReady and fault after a timeout. HALT parks the
// machine until Resume. Two saturating perf counters are kept.
// Outputs are decoded from the state register plus the current
// Opcode/Func/toaccIn/acc15.
// Ports:
//   CLK, Reset_n (sync, active low)
//   Opcode[3:0], Func[2:0], toaccIn, acc15, noOp   - instruction fields/status
//   MemReady, Resume                               - handshakes
//   PCWrite..ALUWrite, IorM, ALUCtrl, Jcontrol,
//   destAdr, destData                              - datapath controls
//   Busy, Fault, InstCount, CycleCount             - status / perf counters
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int WAIT_W      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [3:0]       Opcode,
  input  logic [2:0]       Func,
  input  logic             toaccIn,
  input  logic             acc15,
  input  logic             noOp,
  input  logic             MemReady,
  input  logic             Resume,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             MWrite,
  output logic             ItypeSel,
  output logic             Asel,
  output logic             Bsel,
  output logic             Awrite,
  output logic             Bwrite,
  output logic             RegWrite,
  output logic             IsZeroWrite,
  output logic             ALUWrite,
  output logic [1:0]       IorM,
  output logic [2:0]       ALUCtrl,
  output logic [1:0]       Jcontrol,
  output logic [1:0]       destAdr,
  output logic [2:0]       destData,
  output logic             Busy,
  output logic             Fault,
  output logic [CNT_W-1:0] InstCount,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB,
    S_JUMP, S_JAL, S_BRANCH, S_HALT, S_FAULT
  } state_t;

  state_t state, state_nx;
  logic [WAIT_W-1:0] wait_cnt;

  // Opcode classes
  logic is_ld, is_st, is_jr, is_m, is_j, is_jal, is_br, is_imm, is_lui, is_halt, is_r;
  assign is_ld   = (Opcode == 4'd0);
  assign is_st   = (Opcode == 4'd1);
  assign is_jr   = (Opcode == 4'd2);
  assign is_m    = is_ld | is_st | is_jr;
  assign is_j    = (Opcode == 4'd3);
  assign is_jal  = (Opcode == 4'd4);
  assign is_br   = (Opcode == 4'd5) | (Opcode == 4'd6);
  assign is_imm  = (Opcode == 4'd7)  | (Opcode == 4'd8)  | (Opcode == 4'd10) |
                   (Opcode == 4'd11) | (Opcode == 4'd12) | (Opcode == 4'd13);
  assign is_lui  = (Opcode == 4'd9);
  assign is_halt = (Opcode == 4'd14);
  assign is_r    = (Opcode == 4'd15);

  logic br_taken;
  assign br_taken = ((Opcode == 4'd5) & acc15) | ((Opcode == 4'd6) & ~acc15);

  // wait_cnt counts stalls already taken; this cycle is the last allowed
  // stall when it equals MEM_TIMEOUT-1. MemReady in that cycle still wins.
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  logic mem_timeout;
  assign mem_timeout = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);

  always_comb begin
    state_nx    = state;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    MWrite      = 1'b0;
    ItypeSel    = 1'b0;
    Asel        = 1'b0;
    Bsel        = 1'b0;
    Awrite      = 1'b0;
    Bwrite      = 1'b0;
    RegWrite    = 1'b0;
    IsZeroWrite = 1'b0;
    ALUWrite    = 1'b0;
    IorM        = 2'd0;
    ALUCtrl     = 3'd0;
    Jcontrol    = 2'd0;
    destAdr     = 2'd0;
    destData    = 3'd0;
    Busy        = 1'b1;
    Fault       = 1'b0;
    case (state)
      S_RESET: begin
        Busy     = 1'b0;
        state_nx = S_FETCH;
      end
      S_FETCH: begin
        IRWrite = 1'b1;
        MemRead = 1'b1;
        if (MemReady)         state_nx = S_DECODE;
        else if (mem_timeout) state_nx = S_FAULT;
      end
      S_DECODE: begin
        if (noOp) begin
          PCWrite  = 1'b1;
          state_nx = S_FETCH;
        end else begin
          PCWrite  = ~(is_j | is_jal | is_halt);
          Awrite   = 1'b1;
          Bwrite   = 1'b1;
          Asel     = ~is_m;
          Bsel     = is_imm | is_br;
          ItypeSel = is_br | (Opcode == 4'd13);
          if (is_m || is_imm) state_nx = S_EXEC;
          else if (is_r)      state_nx = (Func != 3'd0) ? S_EXEC : S_WB;
          else if (is_j)      state_nx = S_JUMP;
          else if (is_jal)    state_nx = S_JAL;
          else if (is_br)     state_nx = S_BRANCH;
          else if (is_lui)    state_nx = S_WB;
          else                state_nx = S_HALT;
        end
      end
      S_EXEC: begin
        ALUWrite = 1'b1;
        if (is_m) begin
          ALUCtrl  = 3'd1;            // address add
          state_nx = is_jr ? S_JUMP : S_MEM;
        end else begin
          IsZeroWrite = 1'b1;
          state_nx    = S_WB;
          if (is_r) ALUCtrl = Func;
          else begin
            case (Opcode)
              4'd7:    ALUCtrl = 3'd6;
              4'd8:    ALUCtrl = 3'd7;
              4'd10:   ALUCtrl = 3'd4;
              4'd11:   ALUCtrl = 3'd5;
              4'd12:   ALUCtrl = 3'd0;
              4'd13:   ALUCtrl = 3'd1;
              default: ALUCtrl = 3'd0;
            endcase
          end
        end
      end
      S_MEM: begin
        // Controls held stable across the whole stall.
        IorM = 2'd1;
        if (is_ld) begin
          MemRead = 1'b1;
          MWrite  = 1'b1;
        end else begin
          MemWrite = 1'b1;
        end
        if (MemReady)         state_nx = is_ld ? S_WB : S_FETCH;
        else if (mem_timeout) state_nx = S_FAULT;
      end
      S_WB: begin
        RegWrite = 1'b1;
        state_nx = S_FETCH;
        if (is_r) begin
          if (Func != 3'd0) begin
            destAdr  = {1'b0, toaccIn};
            destData = 3'd0;
          end else if (toaccIn) begin
            destAdr  = 2'd1;
            destData = 3'd2;
          end else begin
            destAdr  = 2'd0;
            destData = 3'd3;
          end
        end else if (is_imm) begin
          destAdr  = 2'd1;
          destData = 3'd0;
        end else if (is_lui) begin
          destAdr  = 2'd1;
          destData = 3'd1;
        end else begin
          destAdr  = 2'd1;
          destData = 3'd4;
        end
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        IorM     = 2'd2;
        Jcontrol = is_jr ? 2'd3 : 2'd2;
        state_nx = S_FETCH;
      end
      S_JAL: begin
        RegWrite = 1'b1;
        destAdr  = 2'd2;
        destData = 3'd5;
        PCWrite  = 1'b1;
        IorM     = 2'd2;
        Jcontrol = 2'd2;
        state_nx = S_FETCH;
      end
      S_BRANCH: begin
        Jcontrol = 2'd1;
        ItypeSel = 1'b1;
        IorM     = br_taken ? 2'd2 : 2'd0;
        PCWrite  = br_taken;
        state_nx = S_FETCH;
      end
      S_HALT: begin
        Busy = 1'b0;
        if (Resume) state_nx = S_FETCH;
      end
      S_FAULT: begin
        Busy  = 1'b0;
        Fault = 1'b1;
      end
      default: begin
        Busy     = 1'b0;
        state_nx = S_RESET;
      end
    endcase
  end

  // Retire = any return to fetch from an instruction state; stalls in
  // fetch, the reset exit and the halt exit do not count.
  logic inst_done;
  assign inst_done = (state_nx == S_FETCH) &&
                     !(state inside {S_RESET, S_FETCH, S_HALT});

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state      <= S_RESET;
      wait_cnt   <= '0;
      InstCount  <= '0;
      CycleCount <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        wait_cnt <= '0;
      else if ((state == S_FETCH || state == S_MEM) && !MemReady && wait_cnt != '1)
        wait_cnt <= wait_cnt + 1'b1;
      if (Busy && CycleCount != '1)     CycleCount <= CycleCount + 1'b1;
      if (inst_done && InstCount != '1) InstCount  <= InstCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with CNT_W=4 so counter saturation is
// reachable quickly.
module tb_multicycle_ctrl;
  localparam int CW = 4;

  logic CLK = 1'b0;
  logic Reset_n, toaccIn, acc15, noOp, MemReady, Resume;
  logic [3:0] Opcode;
  logic [2:0] Func;
  logic PCWrite, IRWrite, MemWrite, MemRead, MWrite, ItypeSel, Asel, Bsel;
  logic Awrite, Bwrite, RegWrite, IsZeroWrite, ALUWrite, Busy, Fault;
  logic [1:0] IorM, Jcontrol, destAdr;
  logic [2:0] ALUCtrl, destData;
  logic [CW-1:0] InstCount, CycleCount;

  int n_chk  = 0;
  int n_fail = 0;

  multicycle_ctrl #(.CNT_W(CW), .WAIT_W(4), .MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Opcode(Opcode), .Func(Func),
    .toaccIn(toaccIn), .acc15(acc15), .noOp(noOp), .MemReady(MemReady),
    .Resume(Resume), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .MemRead(MemRead), .MWrite(MWrite),
    .ItypeSel(ItypeSel), .Asel(Asel), .Bsel(Bsel), .Awrite(Awrite),
    .Bwrite(Bwrite), .RegWrite(RegWrite), .IsZeroWrite(IsZeroWrite),
    .ALUWrite(ALUWrite), .IorM(IorM), .ALUCtrl(ALUCtrl),
    .Jcontrol(Jcontrol), .destAdr(destAdr), .destData(destData),
    .Busy(Busy), .Fault(Fault), .InstCount(InstCount),
    .CycleCount(CycleCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  // Two reset edges, leaves Reset_n low in S_RESET.
  task automatic hold_reset();
    Reset_n = 1'b0;
    step();
    step();
  endtask

  // Release reset: next edge lands in S_FETCH.
  task automatic start();
    hold_reset();
    Reset_n = 1'b1;
    step();
  endtask

  initial begin
    Reset_n = 1'b0; Opcode = 4'd0; Func = 3'd0; toaccIn = 1'b0; acc15 = 1'b0;
    noOp = 1'b0; MemReady = 1'b1; Resume = 1'b0;

    // Reset state
    hold_reset();
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_irw", 32'(IRWrite), 0);
    chk("rst_inst", 32'(InstCount), 0);
    chk("rst_cyc", 32'(CycleCount), 0);

    // IMM op 13, zero wait
    Opcode = 4'd13; MemReady = 1'b1;
    Reset_n = 1'b1; step();
    chk("imm_f_irw", 32'(IRWrite), 1);
    chk("imm_f_mrd", 32'(MemRead), 1);
    step();
    chk("imm_d_ityp", 32'(ItypeSel), 1);
    chk("imm_d_pcw", 32'(PCWrite), 1);
    chk("imm_d_bsel", 32'(Bsel), 1);
    step();
    chk("imm_e_alu", 32'(ALUCtrl), 1);
    chk("imm_e_isz", 32'(IsZeroWrite), 1);
    step();
    chk("imm_wb_rw", 32'(RegWrite), 1);
    chk("imm_wb_adr", 32'(destAdr), 1);
    chk("imm_wb_dat", 32'(destData), 0);
    chk("imm_wb_inst", 32'(InstCount), 0);
    step();
    chk("imm_inst", 32'(InstCount), 1);
    chk("imm_cyc", 32'(CycleCount), 4);

    // ld with three stalls in S_MEM
    Opcode = 4'd0;
    start();
    step();
    chk("ld_d_asel", 32'(Asel), 0);
    step();
    chk("ld_e_alu", 32'(ALUCtrl), 1);
    chk("ld_e_isz", 32'(IsZeroWrite), 0);
    MemReady = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) MemReady = 1'b1;
      #1;
      chk("ld_m_iorm", 32'(IorM), 1);
      chk("ld_m_mw", 32'(MWrite), 1);
      step();
    end
    chk("ld_wb_dat", 32'(destData), 4);
    chk("ld_wb_adr", 32'(destAdr), 1);
    step();
    chk("ld_cyc", 32'(CycleCount), 8);
    chk("ld_inst", 32'(InstCount), 1);

    // Branches
    Opcode = 4'd5; acc15 = 1'b1;
    start(); step(); step();
    chk("br5_pcw", 32'(PCWrite), 1);
    chk("br5_jc", 32'(Jcontrol), 1);
    chk("br5_iorm", 32'(IorM), 2);
    step();
    Opcode = 4'd6;
    step(); step();
    chk("br6_pcw", 32'(PCWrite), 0);
    chk("br6_jc", 32'(Jcontrol), 1);
    chk("br6_iorm", 32'(IorM), 0);
    step();
    chk("br_inst", 32'(InstCount), 2);

    // J, JAL, move-to-acc
    Opcode = 4'd3;
    start(); step();
    chk("j_d_pcw", 32'(PCWrite), 0);
    step();
    chk("j_pcw", 32'(PCWrite), 1);
    chk("j_jc", 32'(Jcontrol), 2);
    chk("j_iorm", 32'(IorM), 2);
    step();
    Opcode = 4'd4;
    step(); step();
    chk("jal_adr", 32'(destAdr), 2);
    chk("jal_dat", 32'(destData), 5);
    step();
    Opcode = 4'd15; Func = 3'd0; toaccIn = 1'b1;
    step(); step();
    chk("mov_adr", 32'(destAdr), 1);
    chk("mov_dat", 32'(destData), 2);
    step();
    chk("jjm_inst", 32'(InstCount), 3);
    chk("jjm_cyc", 32'(CycleCount), 9);

    // Reset mid-store
    Opcode = 4'd1; MemReady = 1'b1;
    start(); step(); step();
    MemReady = 1'b0;
    step();
    chk("st_m_mwr", 32'(MemWrite), 1);
    Reset_n = 1'b0;
    step();
    chk("st_r1_mwr", 32'(MemWrite), 0);
    chk("st_r1_iorm", 32'(IorM), 0);
    chk("st_r1_cyc", 32'(CycleCount), 0);
    step();
    chk("st_r2_mwr", 32'(MemWrite), 0);
    Reset_n = 1'b1;
    step();
    chk("st_f_irw", 32'(IRWrite), 1);
    chk("st_f_mwr", 32'(MemWrite), 0);

    // Fetch timeout -> fault on the 16th fetch cycle
    MemReady = 1'b0;
    start();
    for (int c = 1; c <= 15; c++) begin
      chk("to_nofault", 32'(Fault), 0);
      step();
    end
    chk("to_fault", 32'(Fault), 1);
    chk("to_busy", 32'(Busy), 0);
    MemReady = 1'b1;
    step(); step();
    chk("to_stuck", 32'(Fault), 1);
    hold_reset();
    chk("to_cleared", 32'(Fault), 0);

    // Ready on the last allowed stall cycle completes normally
    Opcode = 4'd13; MemReady = 1'b0;
    Reset_n = 1'b1; step();
    for (int c = 1; c < 15; c++) step();
    MemReady = 1'b1;
    step();
    chk("rdy_wins_fault", 32'(Fault), 0);
    chk("rdy_wins_awr", 32'(Awrite), 1);

    // HALT, resume, then saturate counters with noOps
    Opcode = 4'd14; MemReady = 1'b1;
    start(); step();
    chk("h_d_pcw", 32'(PCWrite), 0);
    step();
    chk("h_busy", 32'(Busy), 0);
    step(); step(); step();
    chk("h_cyc", 32'(CycleCount), 2);
    chk("h_inst", 32'(InstCount), 0);
    Resume = 1'b1;
    step();
    Resume = 1'b0;
    chk("h_res_irw", 32'(IRWrite), 1);
    chk("h_res_inst", 32'(InstCount), 0);
    noOp = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(); step();
    end
    chk("sat_inst", 32'(InstCount), 15);
    chk("sat_cyc", 32'(CycleCount), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
